pipe_stage_skid: RTL and testbench

Parametrised pipeline-stage register with valid/ready handshake, a one-entry skid buffer, synchronous flush and optional bubble zeroing. It is the generic successor of the fixed EX/MEM-style stage registers: any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) instantiates it with its own payload width. Downstream back-pressure is absorbed without a combinational ready path, so full throughput is sustained.

---
 rtl/pipe_stage_skid.sv | 129 ++++++++++++
 tb/tb_pipe_stage_skid.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, one-entry skid buffer, flush and optional bubble zeroing.
// Latency: 1 cycle into the main register; a skidded beat moves to main on the first edge where it is taken.
// Backpressure: in_ready comes straight from state (drops only when the skid holds a beat), so there is no out_ready->in_ready path.
module pipe_stage_skid #(
    parameter int unsigned     DATA_W      = 64,
    parameter int unsigned     PC_W        = 64,
    parameter logic [PC_W-1:0] RESET_PC    = PC_W'(64'h8000_0000),
    parameter bit              BUBBLE_ZERO = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic              held,
    output logic [1:0]        occ
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic              main_v;
    logic              skid_v;
    logic              accept;
    logic              take;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid;
    logic              zero_main;
    logic [PC_W-1:0]   skid_pc;
    logic [DATA_W-1:0] skid_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (accept) state_d = ST_BUSY;
                ST_BUSY: begin
                    if (accept && !take)      state_d = ST_FULL;
                    else if (!accept && take) state_d = ST_EMPTY;
                end
                ST_FULL:  if (take) state_d = ST_BUSY;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        main_v         = (state_q == ST_BUSY) || (state_q == ST_FULL);
        skid_v         = (state_q == ST_FULL);
        out_valid      = main_v;
        in_ready       = !skid_v;
        occ            = {1'b0, main_v} + {1'b0, skid_v};
        accept         = in_valid && in_ready;
        take           = main_v && out_ready;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (!flush) begin
            case (state_q)
                ST_EMPTY: load_main_in = accept;
                ST_BUSY: begin
                    load_main_in = accept && take;
                    load_skid    = accept && !take;
                end
                ST_FULL:  load_main_skid = take;
                default:  ;
            endcase
        end
        // Zeroing on every entry into EMPTY; repeating it while already empty is harmless.
        zero_main = BUBBLE_ZERO && (state_d == ST_EMPTY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_pc   <= RESET_PC;
            out_data <= '0;
        end else if (load_main_in) begin
            out_pc   <= in_pc;
            out_data <= in_data;
        end else if (load_main_skid) begin
            out_pc   <= skid_pc;
            out_data <= skid_data;
        end else if (zero_main) begin
            out_data <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_pc   <= '0;
            skid_data <= '0;
        end else if (load_skid) begin
            skid_pc   <= in_pc;
            skid_data <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held <= 1'b0;
        end else begin
            held <= out_valid && !out_ready && !flush;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: two instances share stimulus, dut0 with BUBBLE_ZERO=0 and dut1 with BUBBLE_ZERO=1.
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        flush = 1'b0;
    logic [63:0] in_pc = '0;
    logic [63:0] in_data = '0;

    logic        in_ready0, out_valid0, held0;
    logic [1:0]  occ0;
    logic [63:0] out_pc0, out_data0;
    logic        in_ready1, out_valid1, held1;
    logic [1:0]  occ1;
    logic [63:0] out_pc1, out_data1;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [4:0] st0, st1;
    assign st0 = {out_valid0, in_ready0, occ0, held0};
    assign st1 = {out_valid1, in_ready1, occ1, held1};

    always #5 clk = ~clk;

    pipe_stage_skid #(.BUBBLE_ZERO(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_pc(in_pc), .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
        .out_pc(out_pc0), .out_data(out_data0), .flush(flush), .held(held0), .occ(occ0)
    );

    pipe_stage_skid #(.BUBBLE_ZERO(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_pc(in_pc), .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
        .out_pc(out_pc1), .out_data(out_data1), .flush(flush), .held(held1), .occ(occ1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Status vectors below are {out_valid, in_ready, occ[1:0], held}.
    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        chk_cnt++;
        if (st0 !== 5'b0_1_00_0) $display("FAIL reset_status got %b want %b", st0, 5'b0_1_00_0);
        else pass_cnt++;
        chk_cnt++;
        if (out_pc0 !== 64'h8000_0000 || out_data0 !== 64'h0)
            $display("FAIL reset_regs got pc=%h data=%h want pc=80000000 data=0", out_pc0, out_data0);
        else pass_cnt++;
        #9 rst = 1'b0;
        step();
        chk_cnt++;
        if (st0 !== 5'b0_1_00_0 || st1 !== 5'b0_1_00_0)
            $display("FAIL reset_idle got %b/%b want 01000", st0, st1);
        else pass_cnt++;
    endtask

    task automatic test_streaming();
        logic [4:0] want_st;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            in_data = 64'(k);
            in_pc   = 64'h8000_0000 + 64'(4 * k);
            step();
            want_st = 5'b1_1_01_0;
            chk_cnt++;
            if (out_data0 !== 64'(k) || out_pc0 !== 64'h8000_0000 + 64'(4 * k) || st0 !== want_st)
                $display("FAIL stream[%0d] got data=%h pc=%h st=%b want data=%h st=%b",
                         k, out_data0, out_pc0, st0, k, want_st);
            else pass_cnt++;
        end
        in_valid = 1'b0;
        step();
        chk_cnt++;
        if (st0 !== 5'b0_1_00_0 || out_data0 !== 64'd8 || out_data1 !== 64'd0)
            $display("FAIL stream_drain got st=%b d0=%h d1=%h want 01000 8 0", st0, out_data0, out_data1);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1; out_ready = 1'b1; in_data = 64'hA; in_pc = 64'h100;
        step();
        chk_cnt++;
        if (out_data0 !== 64'hA || st0 !== 5'b1_1_01_0)
            $display("FAIL bp_first got data=%h st=%b want a 11010", out_data0, st0);
        else pass_cnt++;
        in_data = 64'hB; in_pc = 64'h104; out_ready = 1'b0;
        step();
        in_data = 64'hC; in_pc = 64'h108;
        for (int c = 0; c < 3; c++) begin
            chk_cnt++;
            if (out_data0 !== 64'hA || st0 !== 5'b1_0_10_1)
                $display("FAIL bp_hold[%0d] got data=%h st=%b want a 10101", c, out_data0, st0);
            else pass_cnt++;
            if (c < 2) step();
        end
        out_ready = 1'b1;
        step();
        chk_cnt++;
        if (out_data0 !== 64'hB || out_pc0 !== 64'h104 || st0 !== 5'b1_1_01_0)
            $display("FAIL bp_release_b got data=%h pc=%h st=%b want b 104 11010", out_data0, out_pc0, st0);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (out_data0 !== 64'hC || out_pc0 !== 64'h108 || st0 !== 5'b1_1_01_0)
            $display("FAIL bp_release_c got data=%h pc=%h st=%b want c 108 11010", out_data0, out_pc0, st0);
        else pass_cnt++;
        in_valid = 1'b0;
        step();
        chk_cnt++;
        if (st0 !== 5'b0_1_00_0) $display("FAIL bp_empty got st=%b want 01000", st0);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        in_valid = 1'b1; out_ready = 1'b0; in_data = 64'h11; in_pc = 64'h200;
        step();
        in_data = 64'h12; in_pc = 64'h204;
        step();
        chk_cnt++;
        if (st0 !== 5'b1_0_10_1) $display("FAIL flush_prefill got st=%b want 10101", st0);
        else pass_cnt++;
        flush = 1'b1; in_data = 64'hD; in_pc = 64'h208; out_ready = 1'b1;
        step();
        chk_cnt++;
        if (st0 !== 5'b0_1_00_0 || st1 !== 5'b0_1_00_0 || out_data0 !== 64'h11 || out_data1 !== 64'h0 ||
            out_pc0 !== 64'h200 || out_pc1 !== 64'h200)
            $display("FAIL flush_full got st=%b/%b d=%h/%h pc=%h want 01000 11/0 pc 200",
                     st0, st1, out_data0, out_data1, out_pc0);
        else pass_cnt++;
        flush = 1'b0; in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk_cnt++;
            if (out_valid0 !== 1'b0 || out_data0 === 64'hD)
                $display("FAIL flush_no_d[%0d] got valid=%b data=%h want valid=0", c, out_valid0, out_data0);
            else pass_cnt++;
        end
        in_valid = 1'b1; in_data = 64'h21; in_pc = 64'h300;
        step();
        flush = 1'b1; in_data = 64'h22; in_pc = 64'h304;
        step();
        chk_cnt++;
        if (st0 !== 5'b0_1_00_0 || out_data0 !== 64'h21 || out_pc0 !== 64'h300 || out_data1 !== 64'h0)
            $display("FAIL flush_accept_take got st=%b d0=%h pc=%h d1=%h want 01000 21 300 0",
                     st0, out_data0, out_pc0, out_data1);
        else pass_cnt++;
        flush = 1'b0; in_valid = 1'b0;
        step();
    endtask

    task automatic test_bubble_zero();
        in_valid = 1'b1; out_ready = 1'b1; in_data = 64'h55; in_pc = 64'h1234;
        step();
        chk_cnt++;
        if (out_data0 !== 64'h55 || out_data1 !== 64'h55 || st1 !== 5'b1_1_01_0)
            $display("FAIL bubble_load got d=%h/%h st=%b want 55/55 11010", out_data0, out_data1, st1);
        else pass_cnt++;
        in_valid = 1'b0;
        step();
        chk_cnt++;
        if (out_data1 !== 64'h0 || out_pc1 !== 64'h1234 || out_valid1 !== 1'b0)
            $display("FAIL bubble_zero1 got data=%h pc=%h valid=%b want 0 1234 0", out_data1, out_pc1, out_valid1);
        else pass_cnt++;
        chk_cnt++;
        if (out_data0 !== 64'h55 || out_pc0 !== 64'h1234 || out_valid0 !== 1'b0)
            $display("FAIL bubble_hold0 got data=%h pc=%h valid=%b want 55 1234 0", out_data0, out_pc0, out_valid0);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [63:0] q[$];
        logic [63:0] want;
        int          bad_order = 0;
        int          bad_occ   = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            in_valid  = ($urandom_range(1, 0) == 1);
            out_ready = ($urandom_range(1, 0) == 1);
            in_data   = {$urandom(), $urandom()};
            in_pc     = 64'(cyc);
            #1;
            if (out_valid0 && out_ready) begin
                want = (q.size() > 0) ? q.pop_front() : 64'hDEAD_0000_DEAD_0000;
                if (out_data0 !== want || out_data1 !== want) bad_order++;
            end
            if (in_valid && in_ready0) q.push_back(in_data);
            step();
            if (occ0 !== 2'(q.size()) || (in_ready0 && occ0 == 2'd2) || st1 !== st0) bad_occ++;
        end
        chk_cnt++;
        if (bad_order != 0) $display("FAIL random_order got %0d bad beats want 0", bad_order);
        else pass_cnt++;
        chk_cnt++;
        if (bad_occ != 0) $display("FAIL random_occ got %0d bad cycles want 0", bad_occ);
        else pass_cnt++;
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (out_valid0 && q.size() > 0) begin
                want = q.pop_front();
                chk_cnt++;
                if (out_data0 !== want) $display("FAIL random_drain got %h want %h", out_data0, want);
                else pass_cnt++;
            end
            step();
        end
        chk_cnt++;
        if (q.size() != 0 || st0 !== 5'b0_1_00_0)
            $display("FAIL random_empty got left=%0d st=%b want 0 01000", q.size(), st0);
        else pass_cnt++;
    endtask

    task automatic test_reset_midstream();
        in_valid = 1'b1; out_ready = 1'b0; in_data = 64'h77; in_pc = 64'h400;
        step();
        in_data = 64'h78;
        step();
        chk_cnt++;
        if (occ0 !== 2'd2) $display("FAIL rst_prefill got occ=%0d want 2", occ0);
        else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        chk_cnt++;
        if (st0 !== 5'b0_1_00_0 || out_pc0 !== 64'h8000_0000 || out_data0 !== 64'h0)
            $display("FAIL rst_async got st=%b pc=%h data=%h want 01000 80000000 0", st0, out_pc0, out_data0);
        else pass_cnt++;
        #1 rst = 1'b0;
        in_valid = 1'b0;
        step();
        chk_cnt++;
        if (st0 !== 5'b0_1_00_0 || out_data0 !== 64'h0)
            $display("FAIL rst_after got st=%b data=%h want 01000 0", st0, out_data0);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_bubble_zero();
        test_random();
        test_reset_midstream();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
